// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the mult_4x4 sharing arbiter: sequencer state encodings
// and the operand/product widths of the shared multiplier.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESPOND = 2'd2,
    ST_SPARE   = 2'd3
  } state_t;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request found by
// searching upward from ptr, wrapping modulo NUM_REQ (NUM_REQ must be 2**ID_W).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);

  logic [ID_W-1:0] idx_s;

  // Walk offsets from farthest to nearest so the closest requester above ptr wins
  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    idx_s      = '0;
    any_req    = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_s  = ptr + ID_W'(i);
      gnt_id = req[idx_s] ? idx_s : gnt_id;
    end
    gnt_onehot[gnt_id] = any_req;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one mult_4x4 between NUM_REQ requesters: round-robin accept, drive the
// multiplier until mult_done (or timeout), then return the tagged product.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OP_W*NUM_REQ-1:0]   req_a,
  input  logic [OP_W*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [OP_W-1:0]           mult_m,
  output logic [OP_W-1:0]           mult_q,
  output logic                      mult_on,
  input  logic [PROD_W-1:0]         mult_s,
  input  logic                      mult_done,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [PROD_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_r, state_nxt_s;
  logic [OP_W-1:0]     op_a_r, op_b_r;
  logic [ID_W-1:0]     rr_ptr_r, id_r, gnt_id_s;
  logic [NUM_REQ-1:0]  gnt_onehot_s;
  logic                any_req_s, grant_s, done_s, tmo_s;
  logic [7:0]          cnt_r;
  logic [PROD_W-1:0]   rsp_data_r;
  logic                rsp_err_r, mult_on_r, rsp_valid_r, busy_r;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_id     (gnt_id_s),
    .any_req    (any_req_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; grants only in IDLE, and never while reset is held
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    req_ready   = '0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s && !reset) begin
          grant_s     = 1'b1;
          req_ready   = gnt_onehot_s;
          state_nxt_s = ST_COMPUTE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (mult_done) begin
          done_s      = 1'b1;
          state_nxt_s = ST_RESPOND;
        end else if (cnt_r == CNT_LAST) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_RESPOND;
        end else begin
          state_nxt_s = ST_COMPUTE;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESPOND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, round-robin pointer, timeout counter and response payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_r     <= '0;
      op_b_r     <= '0;
      id_r       <= '0;
      rr_ptr_r   <= '0;
      cnt_r      <= 8'd0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else begin
      if (grant_s) begin
        op_a_r   <= req_a[gnt_id_s*OP_W +: OP_W];
        op_b_r   <= req_b[gnt_id_s*OP_W +: OP_W];
        id_r     <= gnt_id_s;
        rr_ptr_r <= gnt_id_s + ID_W'(1);
        cnt_r    <= 8'd0;
      end else if ((state_r == ST_COMPUTE) && !done_s && !tmo_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (done_s) begin
        rsp_data_r <= mult_s;
        rsp_err_r  <= 1'b0;
      end else if (tmo_s) begin
        rsp_data_r <= '0;
        rsp_err_r  <= 1'b1;
      end
    end
  end

  // Status flags registered from the next state so they align with state_r
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_on_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      mult_on_r   <= (state_nxt_s == ST_COMPUTE);
      rsp_valid_r <= (state_nxt_s == ST_RESPOND);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign mult_m    = op_a_r;
  assign mult_q    = op_b_r;
  assign mult_on   = mult_on_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural mult_4x4 stand-in
// whose completion can be disabled to force timeouts.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [3:0]  mult_m, mult_q;
  logic        mult_on;
  logic [7:0]  mult_s;
  logic        mult_done;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        busy;
  logic        done_en;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  assign mult_s    = {4'd0, mult_m} * {4'd0, mult_q};
  assign mult_done = mult_on & done_en;

  mult_share_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mult_m(mult_m), .mult_q(mult_q), .mult_on(mult_on),
    .mult_s(mult_s), .mult_done(mult_done), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b0000; req_a = 16'h0000; req_b = 16'h0000;
    rsp_ready = 1'b0; done_en = 1'b1;
    step(); step();
    chk_cnt++;
    if ({req_ready, mult_on, rsp_valid, busy, rsp_err} !== 8'h00) begin
      err_cnt++; $display("FAIL reset_flags got %b exp 00000000", {req_ready, mult_on, rsp_valid, busy, rsp_err});
    end
    chk_cnt++;
    if ({mult_m, mult_q, rsp_data, rsp_id} !== 18'h0) begin
      err_cnt++; $display("FAIL reset_data got %h exp 0", {mult_m, mult_q, rsp_data, rsp_id});
    end
    reset = 1'b0;
    step();
    chk_cnt++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      err_cnt++; $display("FAIL idle_after_reset busy %b rdy %b exp 0 0000", busy, req_ready);
    end
  endtask

  task automatic test_single();
    set_op(1, 4'd3, 4'd5);
    req_valid = 4'b0010;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++; $display("FAIL single_grant got %b exp 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    chk_cnt++;
    if ({req_ready, mult_on, busy, rsp_valid, mult_m, mult_q} !== {4'b0000, 1'b1, 1'b1, 1'b0, 4'd3, 4'd5}) begin
      err_cnt++; $display("FAIL single_compute got rdy %b on %b busy %b vld %b m %0d q %0d exp 0000 1 1 0 3 5",
                          req_ready, mult_on, busy, rsp_valid, mult_m, mult_q);
    end
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err, mult_on} !== {1'b1, 2'd1, 8'd15, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL single_rsp got vld %b id %0d data %0d err %b on %b exp 1 1 15 0 0",
                          rsp_valid, rsp_id, rsp_data, rsp_err, mult_on);
    end
    rsp_ready = 1'b1;
    step();
    chk_cnt++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL single_done vld %b busy %b exp 0 0", rsp_valid, busy);
    end
  endtask

  // rr_ptr sits at 2 after the grant to requester 1
  task automatic test_rr_skip();
    set_op(0, 4'd7, 4'd2);
    set_op(2, 4'd4, 4'd6);
    req_valid = 4'b0101;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0100) begin
      err_cnt++; $display("FAIL skip_grant2 got %b exp 0100", req_ready);
    end
    step();
    req_valid = 4'b0001;
    chk_cnt++;
    if (mult_m !== 4'd4 || mult_q !== 4'd6) begin
      err_cnt++; $display("FAIL skip_ops2 got %0d %0d exp 4 6", mult_m, mult_q);
    end
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd2, 8'd24, 4'b0000}) begin
      err_cnt++; $display("FAIL skip_rsp2 got vld %b id %0d data %0d rdy %b exp 1 2 24 0000",
                          rsp_valid, rsp_id, rsp_data, req_ready);
    end
    step();
    chk_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL skip_grant0 got %b exp 0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'd14}) begin
      err_cnt++; $display("FAIL skip_rsp0 got vld %b id %0d data %0d exp 1 0 14", rsp_valid, rsp_id, rsp_data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_prod [4];
    exp_prod[0] = 8'd225; exp_prod[1] = 8'd0; exp_prod[2] = 8'd6; exp_prod[3] = 8'd132;
    reset = 1'b1; #1; reset = 1'b0;
    set_op(0, 4'd15, 4'd15);
    set_op(1, 4'd0, 4'd9);
    set_op(2, 4'd2, 4'd3);
    set_op(3, 4'd12, 4'd11);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_cnt++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        err_cnt++; $display("FAIL b2b_grant%0d got %b exp %b", k, req_ready, 4'b0001 << (k % 4));
      end
      step();
      chk_cnt++;
      if (mult_on !== 1'b1 || req_ready !== 4'b0000) begin
        err_cnt++; $display("FAIL b2b_compute%0d on %b rdy %b exp 1 0000", k, mult_on, req_ready);
      end
      step();
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'(k % 4), exp_prod[k % 4], 4'b0000}) begin
        err_cnt++; $display("FAIL b2b_rsp%0d got vld %b id %0d data %0d rdy %b exp 1 %0d %0d 0000",
                            k, rsp_valid, rsp_id, rsp_data, req_ready, k % 4, exp_prod[k % 4]);
      end
      step();
    end
    req_valid = 4'b0000;
    step();
  endtask

  // rr_ptr is 1 here; req0 is still the only requester so it wins
  task automatic test_backpressure();
    set_op(0, 4'd9, 4'd9);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL bp_grant got %b exp 0001", req_ready);
    end
    step(); step();
    for (int c = 0; c < 5; c++) begin
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, 2'd0, 8'd81, 4'b0000, 1'b1}) begin
        err_cnt++; $display("FAIL bp_hold%0d got vld %b id %0d data %0d rdy %b busy %b exp 1 0 81 0000 1",
                            c, rsp_valid, rsp_id, rsp_data, req_ready, busy);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk_cnt++;
    if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b0001}) begin
      err_cnt++; $display("FAIL bp_release got vld %b busy %b rdy %b exp 0 0 0001", rsp_valid, busy, req_ready);
    end
    step();
    req_valid = 4'b0000;
    step(); step();
  endtask

  // rr_ptr is 1 here, so requester 3 wins the search
  task automatic test_timeout();
    int on_cnt;
    done_en = 1'b0;
    rsp_ready = 1'b0;
    set_op(3, 4'd5, 4'd5);
    req_valid = 4'b1000;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b1000) begin
      err_cnt++; $display("FAIL tmo_grant got %b exp 1000", req_ready);
    end
    step();
    req_valid = 4'b0000;
    on_cnt = 0;
    for (int c = 0; c < 40 && mult_on === 1'b1; c++) begin
      on_cnt++;
      step();
    end
    chk_cnt++;
    if (on_cnt != 15) begin
      err_cnt++; $display("FAIL tmo_on_cycles got %0d exp 15", on_cnt);
    end
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd3, 8'd0, 1'b1}) begin
      err_cnt++; $display("FAIL tmo_rsp got vld %b id %0d data %0d err %b exp 1 3 0 1",
                          rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    done_en = 1'b1;
    step();
    set_op(1, 4'd6, 4'd7);
    req_valid = 4'b0010;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++; $display("FAIL tmo_next_grant got %b exp 0010", req_ready);
    end
    step();
    req_valid = 4'b0000;
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd1, 8'd42, 1'b0}) begin
      err_cnt++; $display("FAIL tmo_next_rsp got vld %b id %0d data %0d err %b exp 1 1 42 0",
                          rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    done_en = 1'b0;
    rsp_ready = 1'b0;
    set_op(2, 4'd10, 4'd3);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    chk_cnt++;
    if (mult_on !== 1'b1) begin
      err_cnt++; $display("FAIL rst_c_pre on %b exp 1", mult_on);
    end
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({mult_on, busy, rsp_valid, req_ready, mult_m, mult_q, rsp_data, rsp_id, rsp_err} !== 27'h0) begin
      err_cnt++; $display("FAIL rst_compute got on %b busy %b vld %b rdy %b m %0d q %0d exp all 0",
                          mult_on, busy, rsp_valid, req_ready, mult_m, mult_q);
    end
    @(negedge clk);
    reset = 1'b0;
    done_en = 1'b1;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'd30}) begin
      err_cnt++; $display("FAIL rst_r_pre got vld %b data %0d exp 1 30", rsp_valid, rsp_data);
    end
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({rsp_valid, busy, rsp_data, rsp_id, rsp_err, mult_m} !== 17'h0) begin
      err_cnt++; $display("FAIL rst_respond got vld %b busy %b data %0d id %0d err %b m %0d exp all 0",
                          rsp_valid, busy, rsp_data, rsp_id, rsp_err, mult_m);
    end
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL rst_ptr_grant got %b exp 0001", req_ready);
    end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_skip();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one mult_4x4 datapath between NUM_REQ requesters. The block accepts one operand pair at a time, drives the multiplier's m/q/mult_on inputs and waits for mult_done. It then returns the 8-bit product, tagged with the requester ID, on a valid/ready response channel. It sits between client blocks and a single mult_4x4 instance and replaces per-client multipliers.

Parameters:
NUM_REQ, 4, number of requesters; must be a power of 2, from 2 to 8.
ID_W, 2, requester ID width; equals log2(NUM_REQ).
TIMEOUT, 15, maximum number of COMPUTE cycles to wait for mult_done before returning an error; range 1..255.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_a  in  4*NUM_REQ  multiplicand; requester i uses bits [4i+3:4i].
req_b  in  4*NUM_REQ  multiplier; requester i uses bits [4i+3:4i].
req_ready  out  NUM_REQ  one-hot acceptance strobe (combinational).
mult_m  out  4  operand to the mult_4x4 m input.
mult_q  out  4  operand to the mult_4x4 q input.
mult_on  out  1  enable to the mult_4x4 mult_on input.
mult_s  in  8  product from mult_4x4.
mult_done  in  1  completion flag from mult_4x4.
rsp_valid  out  1  response valid.
rsp_id  out  ID_W  ID of the requester that owns the response.
rsp_data  out  8  product; 0 on error.
rsp_err  out  1  timeout flag, qualified by rsp_valid.
rsp_ready  in  1  response consumer ready.
busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; rr_ptr=0; operand registers, rsp_data, rsp_id and the timeout counter=0; rsp_valid=0; rsp_err=0; mult_on=0; req_ready=0; busy=0.
- State machine: IDLE -> COMPUTE -> RESPOND -> IDLE, encoded in 2 bits. The fourth encoding recovers to IDLE.
- IDLE:
  - If any req_valid is high, select the winner: the first asserted index found by searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Drive req_ready[winner]=1 in that same cycle. The transfer occurs on that cycle's clock edge.
  - Register req_a/req_b of the winner, register its ID, set rr_ptr=(winner+1) mod NUM_REQ, clear the counter and go to COMPUTE.
  - If no req_valid is high, stay in IDLE.
- req_ready is 0 in all other states; a req_valid asserted outside IDLE is not accepted.
- A requester may drop req_valid before it is granted without consequence.
- COMPUTE:
  - mult_on=1; mult_m and mult_q come from the operand registers.
  - Each cycle, if mult_done=1: rsp_data<=mult_s, rsp_err<=0, go to RESPOND.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without mult_done: rsp_data<=0, rsp_err<=1, go to RESPOND.
- RESPOND:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable.
  - When rsp_ready=1, the handshake completes on that edge and the next state is IDLE.
  - No new grant is issued in the handshake cycle. Back-to-back acceptance therefore happens no earlier than the following cycle.
- mult_on is 0 outside COMPUTE. mult_m and mult_q keep their registered values at all times (no glitching to 0).
- Latency with a combinational mult_done: accept at edge N, COMPUTE during cycle N+1, rsp_valid from cycle N+2. Minimum throughput is one operation per 3 cycles.
- rsp_ready may already be high when RESPOND is entered; the response then completes after exactly one valid cycle.
- Arithmetic: unsigned 4x4 -> 8 bits, no truncation (15*15=225). The block does not recompute or check the product.
- Reset mid-operation: return to IDLE immediately. Any pending response is discarded, rsp_valid drops asynchronously and rr_ptr returns to 0.
- Invariant: at most one req_ready bit is high in any cycle.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_COMPUTE=2'd1, ST_RESPOND=2'd2;
  - constants OP_W=4 and PROD_W=8.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req[NUM_REQ] and ptr[ID_W]; outputs are gnt_onehot, gnt_id and any_req. It is reusable by future shared-resource controllers.
- Top level holds the state machine, registers and timeout counter, and instantiates one rr_pick.

Test Plan:
- Req1 only, a=3, b=5, with a real mult_4x4 attached -> req_ready=0010 for one cycle; rsp_valid two cycles later with rsp_id=1, rsp_data=15, rsp_err=0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 3 cycles apart; products match each requester's pair (15*15=225, 0*9=0).
- After a grant to 1, only requesters 0 and 2 valid -> 2 granted before 0.
- rsp_ready held low for 5 cycles in RESPOND while req0 is valid -> rsp_valid/rsp_data stable, no req_ready, busy=1; rsp_ready=1 -> IDLE, then req0 granted the next cycle.
- mult_done stubbed to 0, TIMEOUT=15 -> mult_on high for exactly 15 cycles; rsp_err=1, rsp_data=0; the next request proceeds normally.
- reset asserted mid-COMPUTE and mid-RESPOND -> all outputs return to their reset values immediately; the next grant starts from requester 0.
